// File: rtl/cls_pkg.sv
// Purpose: shared types and constants for the lockstep-cluster recovery sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cls_pkg;

  // Width of the accepted-fault counter exposed on retry_cnt_o.
  localparam int CLS_RETRY_W = 4;

  // Recovery sequencer states; encoding is visible to debug tooling, keep it fixed.
  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    FAILED = 2'd3
  } cls_rec_state_t;

endpackage

// File: rtl/cls_window_timer.sv
// Purpose: loadable up-counter that pulses expire on its last value and wraps to 0.
// Latency: expire is combinational from the count register; clear/count take effect next edge.
// Backpressure: none; counts only while count_en is high, clear has priority.
module cls_window_timer
  import cls_pkg::*;
#(
  parameter int LIMIT = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  assign expire = count_en && (cnt_q == LAST);

  // Count while enabled; reload to zero on clear or after the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cls_recovery_ctrl.sv
// Purpose: resets the triple-lockstep cluster on divergence, masks compare while it restarts, parks it after too many retries.
// Latency: one cycle from fault_i in RUN to fault_evt_o / core_rst_no low; all outputs registered.
// Backpressure: none; fault_i is a level sampled only in RUN. Build option CLS_FAULT_LOG_EN adds the fault timestamp log.
module cls_recovery_ctrl
  import cls_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRIES   = 3,
  parameter int WINDOW_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fault_i,
  input  logic                   clear_i,
  input  logic                   fetch_enable_i,
  output logic                   core_rst_no,
  output logic                   fetch_en_o,
  output logic                   cmp_mask_o,
  output logic                   fault_evt_o,
  output logic [CLS_RETRY_W-1:0] retry_cnt_o,
  output logic                   failed_o,
  output logic [31:0]            last_fault_ts_o
);

  // HOLD and SETTLE never overlap, so one phase counter sized for the longer one serves both.
  localparam int PH_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]        HOLD_LAST   = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0]        SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [CLS_RETRY_W-1:0] RETRY_MAX   = CLS_RETRY_W'(MAX_RETRIES);

  cls_rec_state_t         state_q;
  cls_rec_state_t         state_nx;
  logic [PH_W-1:0]        phase_q;
  logic [PH_W-1:0]        phase_nx;
  logic [CLS_RETRY_W-1:0] retry_nx;
  logic                   fault_acc;
  logic                   clear_acc;
  logic                   win_expire;
  logic                   cores_live_nx;

  // Retry window: counts RUN cycles, restarts on every accepted fault and on software clear.
  cls_window_timer #(
    .LIMIT(WINDOW_CYCLES)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .count_en (state_q == RUN),
    .clear    (fault_acc | clear_acc),
    .expire   (win_expire)
  );

  // Next-state, phase and retry budget; a fault in the expiry cycle beats the window refill.
  always_comb begin
    state_nx  = state_q;
    phase_nx  = phase_q;
    retry_nx  = retry_cnt_o;
    fault_acc = 1'b0;
    clear_acc = 1'b0;
    case (state_q)
      HOLD: begin
        if (phase_q == HOLD_LAST) begin
          state_nx = SETTLE;
          phase_nx = '0;
        end else begin
          phase_nx = phase_q + 1'b1;
        end
      end
      SETTLE: begin
        if (phase_q == SETTLE_LAST) begin
          state_nx = RUN;
          phase_nx = '0;
        end else begin
          phase_nx = phase_q + 1'b1;
        end
      end
      RUN: begin
        if (fault_i) begin
          fault_acc = 1'b1;
          phase_nx  = '0;
          if (retry_cnt_o < RETRY_MAX) begin
            retry_nx = retry_cnt_o + 1'b1;
            state_nx = HOLD;
          end else begin
            state_nx = FAILED;
          end
        end else if (win_expire) begin
          retry_nx = '0;
        end
      end
      FAILED: begin
        if (clear_i) begin
          clear_acc = 1'b1;
          retry_nx  = '0;
          phase_nx  = '0;
          state_nx  = HOLD;
        end
      end
      default: begin
        state_nx = HOLD;
        phase_nx = '0;
      end
    endcase
  end

  assign cores_live_nx = (state_nx == SETTLE) || (state_nx == RUN);

  // State, phase counter and retry budget registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD;
      phase_q     <= '0;
      retry_cnt_o <= '0;
    end else begin
      state_q     <= state_nx;
      phase_q     <= phase_nx;
      retry_cnt_o <= retry_nx;
    end
  end

  // Outputs are decoded from the next state so a fault is reflected one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst_no <= 1'b0;
      fetch_en_o  <= 1'b0;
      cmp_mask_o  <= 1'b1;
      fault_evt_o <= 1'b0;
      failed_o    <= 1'b0;
    end else begin
      core_rst_no <= cores_live_nx;
      fetch_en_o  <= cores_live_nx && fetch_enable_i;
      cmp_mask_o  <= (state_nx != RUN);
      fault_evt_o <= fault_acc;
      failed_o    <= (state_nx == FAILED);
    end
  end

`ifdef CLS_FAULT_LOG_EN
  logic [31:0] ts_cnt_q;

  // Free-running cycle stamp; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
    end
  end

  // Capture the stamp of every accepted fault, including the one that parks the cluster.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fault_ts_o <= '0;
    end else if (fault_acc) begin
      last_fault_ts_o <= ts_cnt_q;
    end
  end
`else
  assign last_fault_ts_o = 32'd0;
`endif

endmodule

// File: tb/tb_cls_recovery_ctrl.sv
// Purpose: directed self-checking bench for cls_recovery_ctrl (short retry window of 8 cycles).
// Latency: checks sampled on the falling edge, one half-cycle after each active edge.
// Backpressure: n/a.
module tb_cls_recovery_ctrl;

  logic        clk;
  logic        rst;
  logic        fault_i;
  logic        clear_i;
  logic        fetch_enable_i;
  logic        core_rst_no;
  logic        fetch_en_o;
  logic        cmp_mask_o;
  logic        fault_evt_o;
  logic [3:0]  retry_cnt_o;
  logic        failed_o;
  logic [31:0] last_fault_ts_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cyc;
  logic [31:0] exp_ts;

  cls_recovery_ctrl #(
    .HOLD_CYCLES  (16),
    .SETTLE_CYCLES(4),
    .MAX_RETRIES  (3),
    .WINDOW_CYCLES(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fault_i        (fault_i),
    .clear_i        (clear_i),
    .fetch_enable_i (fetch_enable_i),
    .core_rst_no    (core_rst_no),
    .fetch_en_o     (fetch_en_o),
    .cmp_mask_o     (cmp_mask_o),
    .fault_evt_o    (fault_evt_o),
    .retry_cnt_o    (retry_cnt_o),
    .failed_o       (failed_o),
    .last_fault_ts_o(last_fault_ts_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release: the stamp a fault driven now would be logged with.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic note_stamp();
`ifdef CLS_FAULT_LOG_EN
    exp_ts = cyc;
`endif
  endtask

  task automatic fault_pulse();
    note_stamp();
    fault_i = 1'b1;
    tick(1);
    fault_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fault_i = 1'b0; clear_i = 1'b0; fetch_enable_i = 1'b1; exp_ts = 32'd0;
    tick(2);
    chk("rst_core_rst_no", 32'(core_rst_no), 0);
    chk("rst_fetch_en",    32'(fetch_en_o),  0);
    chk("rst_cmp_mask",    32'(cmp_mask_o),  1);
    chk("rst_fault_evt",   32'(fault_evt_o), 0);
    chk("rst_retry_cnt",   32'(retry_cnt_o), 0);
    chk("rst_failed",      32'(failed_o),    0);
    chk("rst_ts",          last_fault_ts_o,  0);
    rst = 1'b0;

    // Boot episode: 16 cycles in reset, 4 masked, then RUN
    tick(15);
    chk("boot_hold_low",   32'(core_rst_no), 0);
    chk("boot_hold_fetch", 32'(fetch_en_o),  0);
    tick(1);
    chk("boot_release",    32'(core_rst_no), 1);
    chk("boot_settle_mask",32'(cmp_mask_o),  1);
    chk("boot_settle_fetch",32'(fetch_en_o), 1);
    tick(3);
    chk("boot_settle_end", 32'(cmp_mask_o),  1);
    tick(1);
    chk("boot_run_mask",   32'(cmp_mask_o),  0);
    chk("boot_run_retry",  32'(retry_cnt_o), 0);

    // fetch_enable_i only gates fetch_en_o
    fetch_enable_i = 1'b0;
    tick(1);
    chk("gate_fetch_off",  32'(fetch_en_o),  0);
    chk("gate_core_live",  32'(core_rst_no), 1);
    chk("gate_mask",       32'(cmp_mask_o),  0);
    fetch_enable_i = 1'b1;
    tick(1);
    chk("gate_fetch_on",   32'(fetch_en_o),  1);

    // Single fault
    fault_pulse();
    chk("f1_evt",   32'(fault_evt_o), 1);
    chk("f1_rst",   32'(core_rst_no), 0);
    chk("f1_fetch", 32'(fetch_en_o),  0);
    chk("f1_mask",  32'(cmp_mask_o),  1);
    chk("f1_retry", 32'(retry_cnt_o), 1);
    chk("f1_ts",    last_fault_ts_o,  exp_ts);
    tick(1);
    chk("f1_evt_one", 32'(fault_evt_o), 0);
    tick(14);
    chk("f1_hold_last", 32'(core_rst_no), 0);
    tick(1);
    chk("f1_release",   32'(core_rst_no), 1);
    tick(4);
    chk("f1_run_mask",  32'(cmp_mask_o),  0);

    // Window refill after 8 fault-free RUN cycles
    tick(7);
    chk("win_before", 32'(retry_cnt_o), 1);
    tick(1);
    chk("win_expire", 32'(retry_cnt_o), 0);

    // Build up the budget, then collide a fault with window expiry
    fault_pulse();
    chk("f2_retry", 32'(retry_cnt_o), 1);
    tick(20);
    fault_pulse();
    chk("f3_retry", 32'(retry_cnt_o), 2);
    tick(20);
    tick(7);
    chk("col_before", 32'(retry_cnt_o), 2);
    note_stamp();
    fault_i = 1'b1;
    tick(1);
    fault_i = 1'b0;
    chk("col_retry", 32'(retry_cnt_o), 3);
    chk("col_evt",   32'(fault_evt_o), 1);
    chk("col_ts",    last_fault_ts_o,  exp_ts);
    tick(20);

    // Budget exhausted: park
    fault_pulse();
    chk("fail_evt",    32'(fault_evt_o), 1);
    chk("fail_flag",   32'(failed_o),    1);
    chk("fail_retry",  32'(retry_cnt_o), 3);
    chk("fail_rst",    32'(core_rst_no), 0);
    chk("fail_ts",     last_fault_ts_o,  exp_ts);
    tick(1);
    chk("fail_evt_one",32'(fault_evt_o), 0);
    tick(30);
    chk("park_flag",   32'(failed_o),    1);
    chk("park_rst",    32'(core_rst_no), 0);
    chk("park_fetch",  32'(fetch_en_o),  0);
    chk("park_mask",   32'(cmp_mask_o),  1);
    chk("park_retry",  32'(retry_cnt_o), 3);

    // Software clear leaves FAILED into a fresh reset episode
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("clr_flag",  32'(failed_o),    0);
    chk("clr_retry", 32'(retry_cnt_o), 0);
    chk("clr_rst",   32'(core_rst_no), 0);
    chk("clr_ts",    last_fault_ts_o,  exp_ts);
    tick(15);
    chk("clr_hold_last", 32'(core_rst_no), 0);
    tick(1);
    chk("clr_release",   32'(core_rst_no), 1);
    tick(4);
    chk("clr_run_mask",  32'(cmp_mask_o),  0);

    // clear_i ignored outside FAILED
    clear_i = 1'b1;
    tick(2);
    clear_i = 1'b0;
    chk("clr_run_rst",  32'(core_rst_no), 1);
    chk("clr_run_mask2",32'(cmp_mask_o),  0);

    // Fault held high across SETTLE: accepted only once RUN is reached
    fault_pulse();
    chk("h_first_retry", 32'(retry_cnt_o), 1);
    tick(16);
    chk("h_settle", 32'(core_rst_no), 1);
    fault_i = 1'b1;
    tick(4);
    chk("h_settle_evt",   32'(fault_evt_o), 0);
    chk("h_settle_retry", 32'(retry_cnt_o), 1);
    chk("h_run_mask",     32'(cmp_mask_o),  0);
    note_stamp();
    tick(1);
    fault_i = 1'b0;
    chk("h_run_evt",   32'(fault_evt_o), 1);
    chk("h_run_retry", 32'(retry_cnt_o), 2);
    chk("h_run_ts",    last_fault_ts_o,  exp_ts);
    tick(1);
    chk("h_evt_one",   32'(fault_evt_o), 0);
    tick(20);
    chk("h_back_run",  32'(cmp_mask_o),  0);

    // Asynchronous reset mid-run
    rst = 1'b1;
    #1;
    chk("mid_rst_core",  32'(core_rst_no), 0);
    chk("mid_rst_fetch", 32'(fetch_en_o),  0);
    chk("mid_rst_mask",  32'(cmp_mask_o),  1);
    chk("mid_rst_evt",   32'(fault_evt_o), 0);
    chk("mid_rst_retry", 32'(retry_cnt_o), 0);
    chk("mid_rst_failed",32'(failed_o),    0);
    chk("mid_rst_ts",    last_fault_ts_o,  0);
    tick(1);
    rst = 1'b0;
    tick(15);
    chk("reboot_hold",    32'(core_rst_no), 0);
    tick(1);
    chk("reboot_release", 32'(core_rst_no), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
